frame_mem_arbiter: RTL and testbench
====================================

// Module: frame_mem_arbiter
// PURPOSE
// - Shares the single-port 19200-entry frame RAM between three requesters: the star scanner (read),
//   the clean module (write) and the draw module (write).
// - Sits between those modules and the RAM; replaces the ad-hoc wren-based address mux.
// - Registered grant FSM, burst ownership with a fairness limit, read-valid tracking and out-of-range trapping.
// PARAMETERS
// - ADDR_W      15     RAM address width
// - DATA_W      3      pixel colour width
// - MEM_DEPTH   19200  valid addresses are 0..MEM_DEPTH-1 (160x120)
// - MAX_BURST   16     max consecutive owned cycles while another requester is pending (>=1)
// - RD_LATENCY  1      cycles from read address presented to mem_q valid (>=1)
// PORTS
// - clk          in   1       system clock
// - reset        in   1       synchronous, active-high reset
// - clean_req    in   1       clean module wants ownership; held for the whole burst
// - clean_valid  in   1       issue one write this cycle (only acts when clean_gnt=1)
// - clean_addr   in   ADDR_W  write address
// - clean_data   in   DATA_W  write data
// - clean_gnt    out  1       clean module owns RAM
// - draw_req/draw_valid/draw_addr/draw_data/draw_gnt  same as clean_*, for the draw module
// - scan_req     in   1       scanner wants ownership
// - scan_valid   in   1       issue one read this cycle (only acts when scan_gnt=1)
// - scan_addr    in   ADDR_W  read address
// - scan_gnt     out  1       scanner owns RAM
// - scan_rdata   out  DATA_W  read data (direct from mem_q)
// - scan_rvalid  out  1       scan_rdata valid, RD_LATENCY cycles after issued read
// - mem_addr     out  ADDR_W  to RAM address
// - mem_data     out  DATA_W  to RAM data
// - mem_wren     out  1       to RAM write enable
// - mem_q        in   DATA_W  from RAM q
// - err_oob      out  1       sticky: an access with addr >= MEM_DEPTH was attempted
// BEHAVIOUR
// - Reset: state IDLE, all *_gnt=0, mem_wren=0, mem_addr=0, mem_data=0, scan_rvalid=0, err_oob=0,
//   burst counter=0, read-valid pipeline flushed. Reset mid-burst drops grant on that edge; in-flight read never flagged.
// - States: IDLE, OWN_CLEAN, OWN_DRAW, OWN_SCAN. *_gnt decoded from registered state only (no comb path req->gnt).
// - IDLE: if any req, next state = winner; gnt visible the cycle after req first seen (1-cycle grant latency).
// - Priority (default): clean > draw > scan.
// - OWN_x: stay while x_req=1, unless burst counter reaches MAX_BURST AND another req is pending -> hand over.
// - On x_req=0 or forced release: next state = winner among OTHER pending reqs (forced) / all pending (voluntary),
//   IDLE if none; handover has no idle bubble.
// - Burst counter: clears on every state change, +1 per owned cycle, saturates at MAX_BURST.
// - Access issued when x_gnt & x_valid & addr < MEM_DEPTH: mem_addr/mem_data muxed from owner,
//   mem_wren=1 for clean/draw, 0 for scan. No access: mem_wren=0, mem_addr holds last value.
// - Valid while not granted is ignored (no access, no error).
// - Out-of-range (owner valid, addr >= MEM_DEPTH): access suppressed (wren=0, no rvalid), err_oob set next cycle.
// - scan_rvalid: issued read delayed RD_LATENCY cycles through shift register; reads issued on last owned
//   cycle still return rvalid after grant moves on.
// - Back-to-back reads: one per cycle, rvalid pulses in issue order.
// CONFIGURATION
// - MEMARB_RR_EN defined: winner chosen round-robin, search starts after last owner
//   (clean->draw->scan->clean); last owner resets to scan.
// - MEMARB_RR_EN undefined: fixed priority clean > draw > scan.
// - MAX_BURST release applies in both builds.
// TESTING
// - reset, then scan_req=1, scan_valid=1, addr 0..3 -> scan_gnt high 1 cycle later; 4 rvalid pulses RD_LATENCY after each read, data match preload.
// - clean_req and scan_req same cycle from IDLE -> clean_gnt first; scan_gnt the cycle after clean_req drops, no bubble.
// - scan holds req 40 cycles, draw_req rises at cycle 5 -> scan released after 16 owned cycles, draw_gnt next cycle.
// - clean write addr 19200, data 3'b101 -> mem_wren stays 0, err_oob=1 next cycle and stays until reset.
// - reset pulsed mid-draw-burst with read in flight -> all gnt=0 and scan_rvalid=0 after edge, state IDLE.
// - MEMARB_RR_EN: all three reqs held, MAX_BURST=2 -> ownership rotates clean, draw, scan, clean every 2 cycles.

Source files
------------

// File: rtl/frame_mem_arbiter.sv
// rtl/frame_mem_arbiter.sv - single-port frame RAM arbiter for clean/draw writers and the star scanner
// Fixed priority clean > draw > scan by default; define MEMARB_RR_EN for round-robin winner selection.
module frame_mem_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 3,
  parameter int MEM_DEPTH  = 19200,
  parameter int MAX_BURST  = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clean_req,
  input  logic              clean_valid,
  input  logic [ADDR_W-1:0] clean_addr,
  input  logic [DATA_W-1:0] clean_data,
  output logic              clean_gnt,
  input  logic              draw_req,
  input  logic              draw_valid,
  input  logic [ADDR_W-1:0] draw_addr,
  input  logic [DATA_W-1:0] draw_data,
  output logic              draw_gnt,
  input  logic              scan_req,
  input  logic              scan_valid,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic              scan_gnt,
  output logic [DATA_W-1:0] scan_rdata,
  output logic              scan_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              err_oob
);

  typedef enum logic [1:0] {IDLE, OWN_CLEAN, OWN_DRAW, OWN_SCAN} state_t;

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(MEM_DEPTH);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  burst_q;
  logic              burst_full;
  logic [2:0]        req_vec;
  logic [2:0]        cand;
  logic              own_req;
  logic              acc_valid, acc_wr, in_range, issue, oob;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;
  logic [RD_LATENCY:0] rd_pipe;

  function automatic state_t idx_state(input int idx);
    case (idx)
      0:       return OWN_CLEAN;
      1:       return OWN_DRAW;
      default: return OWN_SCAN;
    endcase
  endfunction

`ifdef MEMARB_RR_EN
  logic [1:0] last_q, last_eff;

  // Search order starts just after the most recent owner: clean -> draw -> scan -> clean.
  function automatic state_t pick_winner(input logic [2:0] c, input logic [1:0] last);
    state_t w;
    int     idx;
    w = IDLE;
    for (int k = 2; k >= 0; k--) begin
      idx = (int'(last) + 1 + k) % 3;
      if (c[idx]) w = idx_state(idx);
    end
    return w;
  endfunction

  always_comb begin
    case (state_q)
      OWN_CLEAN: last_eff = 2'd0;
      OWN_DRAW:  last_eff = 2'd1;
      OWN_SCAN:  last_eff = 2'd2;
      default:   last_eff = last_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) last_q <= 2'd2;
    else       last_q <= last_eff;
  end
`else
  function automatic state_t pick_winner(input logic [2:0] c);
    state_t w;
    w = IDLE;
    for (int k = 2; k >= 0; k--) begin
      if (c[k]) w = idx_state(k);
    end
    return w;
  endfunction
`endif

  assign req_vec    = {scan_req, draw_req, clean_req};
  // burst_q counts owned cycles before the current one, so this fires on the MAX_BURST-th.
  assign burst_full = (burst_q >= CNT_W'(MAX_BURST - 1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cand    = req_vec;
    own_req = 1'b0;
    case (state_q)
      OWN_CLEAN: begin own_req = clean_req; cand = req_vec & 3'b110; end
      OWN_DRAW:  begin own_req = draw_req;  cand = req_vec & 3'b101; end
      OWN_SCAN:  begin own_req = scan_req;  cand = req_vec & 3'b011; end
      default:   ;
    endcase
    if (state_q == IDLE || !own_req || (burst_full && |cand)) begin
`ifdef MEMARB_RR_EN
      state_d = pick_winner(cand, last_eff);
`else
      state_d = pick_winner(cand);
`endif
    end
  end

  always_comb begin
    clean_gnt = (state_q == OWN_CLEAN);
    draw_gnt  = (state_q == OWN_DRAW);
    scan_gnt  = (state_q == OWN_SCAN);
  end

  always_ff @(posedge clk) begin
    if (reset)                                            burst_q <= '0;
    else if (state_d != state_q)                          burst_q <= '0;
    else if (state_q != IDLE && burst_q != CNT_W'(MAX_BURST)) burst_q <= burst_q + 1'b1;
  end

  always_comb begin
    acc_valid = 1'b0;
    acc_wr    = 1'b0;
    acc_addr  = '0;
    acc_data  = '0;
    case (state_q)
      OWN_CLEAN: begin acc_valid = clean_valid; acc_wr = 1'b1; acc_addr = clean_addr; acc_data = clean_data; end
      OWN_DRAW:  begin acc_valid = draw_valid;  acc_wr = 1'b1; acc_addr = draw_addr;  acc_data = draw_data;  end
      OWN_SCAN:  begin acc_valid = scan_valid;  acc_addr = scan_addr; end
      default:   ;
    endcase
  end

  assign in_range = ({1'b0, acc_addr} < DEPTH_C);
  assign issue    = acc_valid & in_range;
  assign oob      = acc_valid & ~in_range;

  // mem_data only follows writes; reads leave the last written value on the bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_wren <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      err_oob  <= 1'b0;
    end else begin
      mem_wren <= issue & acc_wr;
      if (issue)          mem_addr <= acc_addr;
      if (issue & acc_wr) mem_data <= acc_data;
      if (oob)            err_oob  <= 1'b1;
    end
  end

  // Stage 0 marks the address register load; RAM data follows RD_LATENCY cycles later.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe[0] <= issue & ~acc_wr;
      for (int i = 1; i <= RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  assign scan_rvalid = rd_pipe[RD_LATENCY];
  assign scan_rdata  = mem_q;

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// tb/tb_frame_mem_arbiter.sv - directed and randomized checks of frame_mem_arbiter against a reference model
module tb_frame_mem_arbiter;
  localparam int ADDR_W     = 15;
  localparam int DATA_W     = 3;
  localparam int MEM_DEPTH  = 19200;
  localparam int MAX_BURST  = 16;
  localparam int RD_LATENCY = 1;
`ifdef MEMARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              clean_req, clean_valid, clean_gnt;
  logic [ADDR_W-1:0] clean_addr;
  logic [DATA_W-1:0] clean_data;
  logic              draw_req, draw_valid, draw_gnt;
  logic [ADDR_W-1:0] draw_addr;
  logic [DATA_W-1:0] draw_data;
  logic              scan_req, scan_valid, scan_gnt, scan_rvalid;
  logic [ADDR_W-1:0] scan_addr;
  logic [DATA_W-1:0] scan_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data, mem_q;
  logic              mem_wren, err_oob;

  frame_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH),
    .MAX_BURST(MAX_BURST), .RD_LATENCY(RD_LATENCY)
  ) dut (
    .clk(clk), .reset(reset),
    .clean_req(clean_req), .clean_valid(clean_valid), .clean_addr(clean_addr),
    .clean_data(clean_data), .clean_gnt(clean_gnt),
    .draw_req(draw_req), .draw_valid(draw_valid), .draw_addr(draw_addr),
    .draw_data(draw_data), .draw_gnt(draw_gnt),
    .scan_req(scan_req), .scan_valid(scan_valid), .scan_addr(scan_addr),
    .scan_gnt(scan_gnt), .scan_rdata(scan_rdata), .scan_rvalid(scan_rvalid),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_q(mem_q), .err_oob(err_oob)
  );

  function automatic logic [DATA_W-1:0] pattern(input int i);
    return DATA_W'((i * 5 + 3) % 8);
  endfunction

  // Frame RAM: reloads its preload pattern whenever reset is asserted.
  logic [DATA_W-1:0] ram    [MEM_DEPTH];
  logic [DATA_W-1:0] q_pipe [RD_LATENCY];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) ram[i] <= pattern(i);
    end else if (mem_wren) begin
      ram[mem_addr] <= mem_data;
    end
    q_pipe[0] <= ram[mem_addr];
    for (int i = 1; i < RD_LATENCY; i++) q_pipe[i] <= q_pipe[i-1];
  end
  assign mem_q = q_pipe[RD_LATENCY-1];

  // Reference model: owner 0 clean, 1 draw, 2 scan, 3 nobody.
  int                m_owner, m_run, m_last;
  logic              m_wren, m_err;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic [DATA_W-1:0] shadow [MEM_DEPTH];
  int                rd_due[$];
  logic [DATA_W-1:0] rd_dat[$];
  int                cyc;
  int                vectors, miscompares;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic int choose(input logic [2:0] c, input int last);
    int idx;
    for (int k = 0; k < 3; k++) begin
      idx = RR ? (last + 1 + k) % 3 : k;
      if (c[idx]) return idx;
    end
    return 3;
  endfunction

  task automatic model_edge();
    logic [2:0]        r, others;
    logic              v;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    int                nxt;
    cyc++;
    if (reset) begin
      m_owner = 3; m_run = 0; m_last = 2;
      m_wren = 1'b0; m_err = 1'b0; m_addr = '0; m_data = '0;
      rd_due.delete(); rd_dat.delete();
      for (int i = 0; i < MEM_DEPTH; i++) shadow[i] = pattern(i);
    end else begin
      r = {scan_req, draw_req, clean_req};
      m_wren = 1'b0;
      if (m_owner != 3) begin
        case (m_owner)
          0:       begin v = clean_valid; a = clean_addr; d = clean_data; end
          1:       begin v = draw_valid;  a = draw_addr;  d = draw_data;  end
          default: begin v = scan_valid;  a = scan_addr;  d = '0;         end
        endcase
        if (v && int'(a) < MEM_DEPTH) begin
          m_addr = a;
          if (m_owner == 2) begin
            rd_due.push_back(cyc + RD_LATENCY);
            rd_dat.push_back(shadow[a]);
          end else begin
            m_wren = 1'b1; m_data = d; shadow[a] = d;
          end
        end else if (v) begin
          m_err = 1'b1;
        end
      end
      if (m_owner == 3) begin
        nxt = choose(r, m_last);
      end else begin
        others = r;
        others[m_owner] = 1'b0;
        if (!r[m_owner] || (m_run >= MAX_BURST && others != 3'b000)) nxt = choose(others, m_last);
        else nxt = m_owner;
      end
      if (nxt == m_owner) begin
        m_run++;
      end else begin
        m_owner = nxt;
        m_run   = (nxt == 3) ? 0 : 1;
        if (nxt != 3) m_last = nxt;
      end
    end
  endtask

  task automatic check_outputs();
    logic exp_rv;
    chk("clean_gnt", 32'(clean_gnt), 32'(m_owner == 0));
    chk("draw_gnt",  32'(draw_gnt),  32'(m_owner == 1));
    chk("scan_gnt",  32'(scan_gnt),  32'(m_owner == 2));
    chk("mem_wren",  32'(mem_wren),  32'(m_wren));
    chk("mem_addr",  32'(mem_addr),  32'(m_addr));
    chk("mem_data",  32'(mem_data),  32'(m_data));
    chk("err_oob",   32'(err_oob),   32'(m_err));
    exp_rv = (rd_due.size() > 0) && (rd_due[0] == cyc);
    chk("scan_rvalid", 32'(scan_rvalid), 32'(exp_rv));
    if (exp_rv) begin
      chk("scan_rdata", 32'(scan_rdata), 32'(rd_dat[0]));
      void'(rd_due.pop_front());
      void'(rd_dat.pop_front());
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    clean_req = 1'b0; clean_valid = 1'b0; clean_addr = '0; clean_data = '0;
    draw_req  = 1'b0; draw_valid  = 1'b0; draw_addr  = '0; draw_data  = '0;
    scan_req  = 1'b0; scan_valid  = 1'b0; scan_addr  = '0;
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    int r;
    r = int'($urandom_range(0, 63));
    if (r == 0)      return ADDR_W'($urandom_range(MEM_DEPTH, 32767));
    else if (r == 1) return ADDR_W'(MEM_DEPTH - 1);
    else if (r == 2) return ADDR_W'(MEM_DEPTH);
    else if (r < 48) return ADDR_W'($urandom_range(0, 31));
    else             return ADDR_W'($urandom_range(0, MEM_DEPTH - 1));
  endfunction

  initial begin
    int run, handed, rv_seen;
    bit drop_seen;
    vectors = 0; miscompares = 0; cyc = 0;
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    chk("rst_gnts",   32'({clean_gnt, draw_gnt, scan_gnt}), 32'd0);
    chk("rst_wren",   32'(mem_wren), 32'd0);
    chk("rst_addr",   32'(mem_addr), 32'd0);
    chk("rst_err",    32'(err_oob),  32'd0);
    chk("rst_rvalid", 32'(scan_rvalid), 32'd0);
    reset = 1'b0;

    // Scanner reads addresses 0..3 back to back.
    scan_req = 1'b1;
    step();
    chk("t1_gnt_latency", 32'(scan_gnt), 32'd1);
    rv_seen = 0;
    for (int i = 0; i < 7; i++) begin
      scan_valid = (i < 4);
      scan_addr  = ADDR_W'(i);
      step();
      if (scan_rvalid) begin
        chk("t1_rdata", 32'(scan_rdata), 32'(pattern(rv_seen)));
        rv_seen++;
      end
    end
    chk("t1_rvalid_count", 32'(rv_seen), 32'd4);
    idle_inputs();
    step();

    // Clean and scan request together from IDLE.
    clean_req = 1'b1; scan_req = 1'b1;
    step();
    chk("t2_clean_first", 32'({clean_gnt, scan_gnt}), 32'b10);
    for (int i = 0; i < 3; i++) begin
      clean_valid = 1'b1; clean_addr = ADDR_W'(100 + i); clean_data = DATA_W'(i + 4);
      step();
    end
    clean_req = 1'b0; clean_valid = 1'b0;
    step();
    chk("t2_scan_no_bubble", 32'({clean_gnt, scan_gnt}), 32'b01);
    idle_inputs();
    step();

    // Long scan burst with draw pending from cycle 5.
    scan_req = 1'b1; run = 0; handed = 0; drop_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      draw_req = (i >= 5);
      step();
      if (!drop_seen) begin
        if (scan_gnt) run++;
        else begin drop_seen = 1'b1; handed = int'(draw_gnt); end
      end
    end
    chk("t3_scan_burst_len", 32'(run), 32'(MAX_BURST));
    chk("t3_draw_handover", 32'(handed), 32'd1);
    idle_inputs();
    step();
    step();

    // Valid without grant is ignored; out-of-range write is trapped.
    clean_req = 1'b1;
    step();
    draw_valid = 1'b1; draw_addr = ADDR_W'(MEM_DEPTH + 100); draw_data = 3'b111;
    step();
    chk("t4_ungranted_wren", 32'(mem_wren), 32'd0);
    chk("t4_ungranted_err",  32'(err_oob),  32'd0);
    draw_valid = 1'b0;
    clean_valid = 1'b1; clean_addr = ADDR_W'(MEM_DEPTH); clean_data = 3'b101;
    step();
    chk("t4_oob_wren", 32'(mem_wren), 32'd0);
    chk("t4_oob_err",  32'(err_oob),  32'd1);
    clean_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("t4_err_sticky", 32'(err_oob), 32'd1);
    idle_inputs();
    reset = 1'b1;
    step();
    chk("t4_err_cleared", 32'(err_oob), 32'd0);
    reset = 1'b0;

    // Reset lands during a draw burst with a scan read still in flight.
    scan_req = 1'b1;
    step();
    scan_valid = 1'b1; scan_addr = ADDR_W'(7); scan_req = 1'b0; draw_req = 1'b1;
    step();
    chk("t5_draw_owns", 32'(draw_gnt), 32'd1);
    scan_valid = 1'b0;
    reset = 1'b1;
    step();
    chk("t5_rst_gnts",   32'({clean_gnt, draw_gnt, scan_gnt}), 32'd0);
    chk("t5_rst_rvalid", 32'(scan_rvalid), 32'd0);
    reset = 1'b0;
    idle_inputs();
    step();
    chk("t5_idle", 32'({clean_gnt, draw_gnt, scan_gnt}), 32'd0);

    // Randomized traffic with sticky requests and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) clean_req = ~clean_req;
      if ($urandom_range(0, 7) == 0) draw_req  = ~draw_req;
      if ($urandom_range(0, 7) == 0) scan_req  = ~scan_req;
      clean_valid = 1'($urandom_range(0, 1)); clean_addr = rand_addr(); clean_data = DATA_W'($urandom);
      draw_valid  = 1'($urandom_range(0, 1)); draw_addr  = rand_addr(); draw_data  = DATA_W'($urandom);
      scan_valid  = 1'($urandom_range(0, 1)); scan_addr  = rand_addr();
      reset = ($urandom_range(0, 399) == 0);
      step();
    end
    reset = 1'b0;
    idle_inputs();
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
